// File: rtl/simmem_multibank_delay_model.sv
// simmem_multibank_delay_model: N-bank row-buffer timing model with round-robin completion reporting.
// Defining SIMMEM_CLOSED_PAGE_EN selects a closed-page policy; the default is open-page.
module simmem_multibank_delay_model #(
    parameter int NumBanks          = 4,
    parameter int AddrWidth         = 16,
    parameter int RowBufferLenWidth = 8,
    parameter int IidWidth          = 5,
    parameter int RowHitCost        = 4,
    parameter int PrechargeCost     = 5,
    parameter int ActivationCost    = 4,
    parameter int DelayWidth        = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [AddrWidth-1:0]  req_addr_i,
    input  logic [IidWidth-1:0]   req_iid_i,
    output logic                  done_valid_o,
    input  logic                  done_ready_i,
    output logic [IidWidth-1:0]   done_iid_o,
    output logic [DelayWidth-1:0] done_delay_o,
    output logic [NumBanks-1:0]   bank_busy_o
);
    localparam int BankBits = $clog2(NumBanks);
    localparam int IdxW     = BankBits > 0 ? BankBits : 1;
    localparam int RowW     = AddrWidth - RowBufferLenWidth - BankBits;
    localparam int MaxCost  = PrechargeCost + ActivationCost + RowHitCost;
    localparam int CntW     = $clog2(MaxCost + 1);
    localparam int MaxDelay = (1 << DelayWidth) - 1;
    localparam logic [CntW-1:0] COST_HIT      = CntW'(RowHitCost);
    localparam logic [CntW-1:0] COST_EMPTY    = CntW'(ActivationCost + RowHitCost);
    localparam logic [CntW-1:0] COST_CONFLICT = CntW'(MaxCost);
    localparam logic [CntW-1:0] ONE           = CntW'(1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [1:0] PRE  = 2'd3;

    logic [1:0]          state    [NumBanks];
    logic [RowW-1:0]     open_row [NumBanks];
    logic [IidWidth-1:0] iid      [NumBanks];
    logic [CntW-1:0]     cost     [NumBanks];
    logic [CntW-1:0]     cnt      [NumBanks];
    logic [NumBanks-1:0] row_valid;
    logic [NumBanks-1:0] is_done;
    logic [IdxW-1:0]     ptr;
    logic [IdxW-1:0]     lock_idx;
    logic [IdxW-1:0]     rr_idx;
    logic [IdxW-1:0]     grant;
    logic [IdxW-1:0]     req_bank;
    logic [RowW-1:0]     req_row;
    logic [CntW-1:0]     req_cost;
    logic                lock_vld;
    logic                accept;
    logic                handshake;
    logic                row_hit;
    logic                unused_col;

    if (BankBits > 0) begin : g_bank
        assign req_bank = req_addr_i[RowBufferLenWidth +: BankBits];
    end else begin : g_single
        assign req_bank = '0;
    end

    assign req_row    = req_addr_i[AddrWidth-1 -: RowW];
    assign unused_col = ^req_addr_i[RowBufferLenWidth-1:0];
    assign row_hit    = row_valid[req_bank] && open_row[req_bank] == req_row;

`ifdef SIMMEM_CLOSED_PAGE_EN
    logic unused_hit;
    assign unused_hit = row_hit;
    assign req_cost   = COST_EMPTY;
`else
    assign req_cost = !row_valid[req_bank] ? COST_EMPTY : row_hit ? COST_HIT : COST_CONFLICT;
`endif

    assign req_ready_o = !rst_i && state[req_bank] == IDLE;
    assign accept      = req_valid_i && req_ready_o;

    always_comb begin
        for (int b = 0; b < NumBanks; b++) begin
            is_done[b]     = state[b] == DONE;
            bank_busy_o[b] = !rst_i && state[b] != IDLE;
        end
    end

    // Scan downwards so the DONE bank nearest the pointer is the last one written.
    always_comb begin
        rr_idx = ptr;
        for (int k = NumBanks - 1; k >= 0; k--)
            if (is_done[IdxW'((int'(ptr) + k) % NumBanks)]) rr_idx = IdxW'((int'(ptr) + k) % NumBanks);
    end

    // A stalled winner is locked so a bank finishing later cannot displace it.
    assign grant        = lock_vld ? lock_idx : rr_idx;
    assign done_valid_o = !rst_i && |is_done;
    assign handshake    = done_valid_o && done_ready_i;
    assign done_iid_o   = done_valid_o ? iid[grant] : '0;
    assign done_delay_o = !done_valid_o ? '0 :
                          int'(cost[grant]) > MaxDelay ? DelayWidth'(MaxDelay) : DelayWidth'(cost[grant]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr       <= '0;
            lock_vld  <= 1'b0;
            lock_idx  <= '0;
            row_valid <= '0;
            for (int b = 0; b < NumBanks; b++) begin
                state[b]    <= IDLE;
                open_row[b] <= '0;
                iid[b]      <= '0;
                cost[b]     <= '0;
                cnt[b]      <= '0;
            end
        end else begin
            lock_vld <= done_valid_o && !done_ready_i;
            lock_idx <= grant;
            if (handshake) ptr <= IdxW'((int'(grant) + 1) % NumBanks);
            for (int b = 0; b < NumBanks; b++) begin
                case (state[b])
                    IDLE: if (accept && req_bank == IdxW'(b)) begin
                        state[b]     <= BUSY;
                        cnt[b]       <= req_cost;
                        cost[b]      <= req_cost;
                        iid[b]       <= req_iid_i;
                        open_row[b]  <= req_row;
                        row_valid[b] <= 1'b1;
                    end
                    BUSY: begin
                        cnt[b] <= cnt[b] - ONE;
                        if (cnt[b] == ONE) state[b] <= DONE;
                    end
                    DONE: if (handshake && grant == IdxW'(b)) begin
`ifdef SIMMEM_CLOSED_PAGE_EN
                        row_valid[b] <= 1'b0;
                        cnt[b]       <= CntW'(PrechargeCost);
                        state[b]     <= PrechargeCost > 0 ? PRE : IDLE;
`else
                        state[b] <= IDLE;
`endif
                    end
                    default: begin
                        cnt[b] <= cnt[b] - ONE;
                        if (cnt[b] == ONE) state[b] <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_simmem_multibank_delay_model.sv
// tb_simmem_multibank_delay_model: directed scenarios plus random traffic against a cycle-count reference model.
module tb_simmem_multibank_delay_model;
    localparam int NB = 4, HIT = 4, PRE = 5, ACT = 4, MAXD = 63;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        done_ready_i = 1'b0;
    logic [15:0] req_addr_i = '0;
    logic [4:0]  req_iid_i = '0;
    logic        req_ready_o;
    logic        done_valid_o;
    logic [4:0]  done_iid_o;
    logic [5:0]  done_delay_o;
    logic [3:0]  bank_busy_o;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk_i = ~clk_i;

    simmem_multibank_delay_model dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_iid_i(req_iid_i),
        .done_valid_o(done_valid_o), .done_ready_i(done_ready_i),
        .done_iid_o(done_iid_o), .done_delay_o(done_delay_o),
        .bank_busy_o(bank_busy_o)
    );

    // Reference model: each request finishes at an absolute cycle number.
    int   m_cyc = 0;
    bit   m_inflight [NB];
    bit   m_pre [NB];
    bit   m_rv [NB];
    int   m_done_at [NB];
    int   m_free_at [NB];
    int   m_iid [NB];
    int   m_cost [NB];
    int   m_row [NB];
    int   m_ptr, m_lock_bank, e_win;
    bit   m_lock, e_ready, e_valid;
    logic [3:0] e_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int cost_of(int b, int row);
`ifdef SIMMEM_CLOSED_PAGE_EN
        return ACT + HIT;
`else
        if (!m_rv[b]) return ACT + HIT;
        return m_row[b] == row ? HIT : PRE + ACT + HIT;
`endif
    endfunction

    task automatic model_clear();
        for (int b = 0; b < NB; b++) begin
            m_inflight[b] = 0; m_pre[b] = 0; m_rv[b] = 0;
            m_done_at[b] = 0; m_free_at[b] = 0; m_iid[b] = 0; m_cost[b] = 0; m_row[b] = 0;
        end
        m_ptr = 0; m_lock = 0; m_lock_bank = 0;
    endtask

    task automatic model_eval();
        int b;
        e_busy = '0;
        for (int i = 0; i < NB; i++) e_busy[i] = m_inflight[i] || (m_pre[i] && m_cyc < m_free_at[i]);
        e_ready = !e_busy[req_addr_i[9:8]];
        e_valid = 0;
        e_win = 0;
        if (m_lock) begin
            e_valid = 1;
            e_win = m_lock_bank;
        end else begin
            for (int k = 0; k < NB; k++) begin
                b = (m_ptr + k) % NB;
                if (!e_valid && m_inflight[b] && m_cyc >= m_done_at[b]) begin
                    e_valid = 1;
                    e_win = b;
                end
            end
        end
    endtask

    task automatic model_update();
        bit hs, acc;
        int b, row;
        hs = e_valid && done_ready_i;
        acc = req_valid_i && e_ready;
        m_cyc++;
        if (hs) begin
            m_inflight[e_win] = 0;
            m_ptr = (e_win + 1) % NB;
`ifdef SIMMEM_CLOSED_PAGE_EN
            m_pre[e_win] = 1;
            m_free_at[e_win] = m_cyc + PRE;
            m_rv[e_win] = 0;
`endif
        end
        m_lock = e_valid && !done_ready_i;
        m_lock_bank = e_win;
        if (acc) begin
            b = int'(req_addr_i[9:8]);
            row = int'(req_addr_i[15:10]);
            m_cost[b] = cost_of(b, row);
            m_inflight[b] = 1;
            m_pre[b] = 0;
            m_done_at[b] = m_cyc + m_cost[b];
            m_iid[b] = int'(req_iid_i);
            m_row[b] = row;
            m_rv[b] = 1;
        end
    endtask

    task automatic step(input logic v, input logic [15:0] a, input logic [4:0] id, input logic dr);
        @(negedge clk_i);
        rst_i = 0; req_valid_i = v; req_addr_i = a; req_iid_i = id; done_ready_i = dr;
        #1;
        model_eval();
        check("ready", req_ready_o, e_ready);
        check("valid", done_valid_o, e_valid);
        check("iid", done_iid_o, e_valid ? m_iid[e_win] : 0);
        check("delay", done_delay_o, e_valid ? (m_cost[e_win] > MAXD ? MAXD : m_cost[e_win]) : 0);
        check("busy", bank_busy_o, e_busy);
        @(posedge clk_i);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1; req_valid_i = 0; done_ready_i = 0;
        #1;
        check("rst_ready", req_ready_o, 0);
        check("rst_valid", done_valid_o, 0);
        check("rst_busy", bank_busy_o, 0);
        check("rst_iid", done_iid_o, 0);
        check("rst_delay", done_delay_o, 0);
        @(posedge clk_i);
        model_clear();
        #1;
    endtask

    // Call right after the accepting step: checks the exact completion cycle, then hands it over.
    task automatic expect_done(input int id, input int cost);
        repeat (cost - 1) step(0, 16'h0000, 0, 0);
        check("early_valid", done_valid_o, 0);
        step(0, 16'h0000, 0, 0);
        check("on_time_valid", done_valid_o, 1);
        check("done_iid", done_iid_o, id);
        check("done_delay", done_delay_o, cost);
        step(0, 16'h0000, 0, 1);
    endtask

    task automatic drain(input int n);
        repeat (n) step(0, 16'h0000, 0, 1);
    endtask

    initial begin
        int seen [$];
        logic [15:0] a;
        model_clear();
        do_reset();
        do_reset();
        // empty row, row hit, row conflict on bank 0
        step(1, 16'h0000, 3, 0);
        expect_done(3, 8);
        step(1, 16'h0004, 4, 0);
        expect_done(4, 4);
        step(1, 16'h0400, 5, 0);
        expect_done(5, 13);
        // busy bank refuses, another bank accepts; both finish independently
        step(1, 16'h0000, 6, 0);
        step(1, 16'h0000, 7, 0);
        check("blocked_ready", req_ready_o, 0);
        step(1, 16'h0100, 8, 0);
        for (int i = 0; i < 25; i++) begin
            step(0, 16'h0000, 0, 1);
            if (done_valid_o) seen.push_back(int'(done_iid_o));
        end
        check("pair_count", seen.size(), 2);
        if (seen.size() == 2) begin
            check("pair_first", seen[0], 8);
            check("pair_second", seen[1], 6);
        end
        // simultaneous DONE on banks 1 and 2 with the pointer at 0
        do_reset();
        step(1, 16'h0100, 1, 1);
        drain(10);
        step(1, 16'h0300, 2, 1);
        drain(10);
        step(1, 16'h0200, 12, 0);
        repeat (3) step(0, 16'h0000, 0, 0);
        step(1, 16'h0100, 11, 0);
        repeat (4) step(0, 16'h0000, 0, 0);
        for (int i = 0; i < 3; i++) begin
            check("hold_valid", done_valid_o, 1);
            check("hold_iid", done_iid_o, 11);
            check("hold_delay", done_delay_o, 4);
            if (i < 2) step(0, 16'h0000, 0, 0);
        end
        step(0, 16'h0000, 0, 1);
        check("second_iid", done_iid_o, 12);
        check("second_delay", done_delay_o, 8);
        step(0, 16'h0000, 0, 1);
        check("drained_valid", done_valid_o, 0);
        // pointer now at 3: bank 3 must win over bank 0
        step(1, 16'h0000, 13, 0);
        repeat (3) step(0, 16'h0000, 0, 0);
        step(1, 16'h0300, 14, 0);
        repeat (4) step(0, 16'h0000, 0, 0);
        check("ptr3_iid", done_iid_o, 14);
        drain(4);
        // reset while bank 0 is busy
        step(1, 16'h0000, 9, 0);
        repeat (3) step(0, 16'h0000, 0, 0);
        do_reset();
        check("rst_mid_busy", bank_busy_o, 0);
        repeat (12) begin
            step(0, 16'h0000, 0, 1);
            check("no_stale_done", done_valid_o, 0);
        end
        step(1, 16'h0000, 9, 0);
        expect_done(9, 8);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            a = 16'(($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 8) | $urandom_range(0, 255));
            step(1'($urandom_range(0, 1)), a, 5'($urandom), 1'($urandom_range(0, 9) < 7));
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
